instruction_fetch: RTL and testbench

Fetch stage for the 16-bit core. It sits directly upstream of the instruction decoder. On request it reads one instruction word from program memory at the supplied PC through a req/ready handshake, then holds it as a registered, valid-qualified instruction until the decode/execute side acknowledges it. It also provides flush, memory-timeout recovery (substituting a no-op word) and a fetch counter.

---
 rtl/instruction_fetch.sv | 119 +++++++++++
 tb/tb_instruction_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: reads one 16-bit instruction per request from program memory and
// holds it, valid-qualified, until the decoder acknowledges it.
module instruction_fetch #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          TIMEOUT    = 15,
    parameter logic [15:0] NOP_INSTR  = 16'h1800
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  fetch_start,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [15:0]           instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ack,
    output logic                  fetch_error,
    output logic [15:0]           fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Abort fires on the edge that closes the TIMEOUT-th request cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_req_q;
    logic [15:0]           instr_out_q;
    logic [ADDR_WIDTH-1:0] instr_pc_q;
    logic                  instr_valid_q;
    logic                  fetch_error_q;
    logic [15:0]           fetch_count_q;
    logic [7:0]            cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_req_q     <= 1'b0;
            instr_out_q   <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_error_q <= 1'b0;
            fetch_count_q <= 16'd0;
            cnt_q         <= 8'd0;
        end else begin
            fetch_error_q <= 1'b0;
            if (flush) begin
                // Dropping mem_req cancels the access; any returning data is lost.
                state_q       <= IDLE;
                mem_req_q     <= 1'b0;
                instr_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fetch_start) begin
                            mem_addr_q <= pc_in;
                            instr_pc_q <= pc_in;
                            mem_req_q  <= 1'b1;
                            cnt_q      <= 8'd0;
                            state_q    <= REQ;
                        end
                    end
                    REQ: begin
                        if (mem_ready) begin
                            instr_out_q   <= mem_rdata;
                            instr_valid_q <= 1'b1;
                            mem_req_q     <= 1'b0;
                            fetch_count_q <= fetch_count_q + 16'd1;
                            state_q       <= HOLD;
                        end else if (cnt_q == TO_LAST) begin
                            instr_out_q   <= NOP_INSTR;
                            instr_valid_q <= 1'b1;
                            mem_req_q     <= 1'b0;
                            fetch_error_q <= 1'b1;
                            fetch_count_q <= fetch_count_q + 16'd1;
                            state_q       <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    HOLD: begin
                        if (instr_ack) begin
                            instr_valid_q <= 1'b0;
                            if (fetch_start) begin
                                mem_addr_q <= pc_in;
                                instr_pc_q <= pc_in;
                                mem_req_q  <= 1'b1;
                                cnt_q      <= 8'd0;
                                state_q    <= REQ;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_req     = mem_req_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_error = fetch_error_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: hand-computed expectations per step.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc_in;
    logic        fetch_start;
    logic        flush;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ack;
    logic        fetch_error;
    logic [15:0] fetch_count;

    int vecs = 0;
    int errs = 0;
    int hi_cycles;

    instruction_fetch dut (
        .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .fetch_start(fetch_start),
        .flush(flush), .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ack(instr_ack), .fetch_error(fetch_error),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; pc_in = '0; fetch_start = 0; flush = 0;
        mem_rdata = '0; mem_ready = 0; instr_ack = 0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'h0);
        chk("rst_out",   32'(instr_out), 32'h1800);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_err",   32'(fetch_error), 32'd0);
        chk("rst_cnt",   32'(fetch_count), 32'd0);

        // zero-wait fetch
        pc_in = 16'h0040; fetch_start = 1;
        tick();
        chk("zw_req",  32'(mem_req), 32'd1);
        chk("zw_addr", 32'(mem_addr), 32'h0040);
        fetch_start = 0; mem_ready = 1; mem_rdata = 16'h8005;
        tick();
        chk("zw_valid", 32'(instr_valid), 32'd1);
        chk("zw_out",   32'(instr_out), 32'h8005);
        chk("zw_pc",    32'(instr_pc), 32'h0040);
        chk("zw_cnt",   32'(fetch_count), 32'd1);
        chk("zw_reqlo", 32'(mem_req), 32'd0);
        mem_ready = 0; instr_ack = 1;
        tick();
        chk("zw_ack", 32'(instr_valid), 32'd0);
        instr_ack = 0;

        // 3 wait states, ack delayed 4 cycles
        pc_in = 16'h0100; fetch_start = 1;
        tick();
        fetch_start = 0; pc_in = 16'h0F0F;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_req",  32'(mem_req), 32'd1);
            chk("ws_addr", 32'(mem_addr), 32'h0100);
        end
        mem_ready = 1; mem_rdata = 16'h2A61;
        tick();
        mem_ready = 0; mem_rdata = 16'hFFFF;
        chk("ws_valid", 32'(instr_valid), 32'd1);
        chk("ws_cnt",   32'(fetch_count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            fetch_start = (i == 1);
            tick();
            chk("hold_out",   32'(instr_out), 32'h2A61);
            chk("hold_pc",    32'(instr_pc), 32'h0100);
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_noreq", 32'(mem_req), 32'd0);
        end
        fetch_start = 0; instr_ack = 1;
        tick();
        chk("hold_ack", 32'(instr_valid), 32'd0);
        instr_ack = 0;
        tick();
        chk("idle_req", 32'(mem_req), 32'd0);

        // timeout with a stray fetch_start during REQ
        pc_in = 16'h0200; fetch_start = 1;
        tick();
        hi_cycles = 0;
        while (mem_req === 1'b1 && hi_cycles < 40) begin
            hi_cycles++;
            fetch_start = (hi_cycles == 3);
            pc_in = 16'h0300;
            if (hi_cycles == 5) chk("to_addr", 32'(mem_addr), 32'h0200);
            tick();
        end
        fetch_start = 0;
        chk("to_cycles", 32'(hi_cycles), 32'd15);
        chk("to_out",   32'(instr_out), 32'h1800);
        chk("to_valid", 32'(instr_valid), 32'd1);
        chk("to_err",   32'(fetch_error), 32'd1);
        chk("to_pc",    32'(instr_pc), 32'h0200);
        chk("to_cnt",   32'(fetch_count), 32'd3);
        tick();
        chk("to_err1", 32'(fetch_error), 32'd0);
        chk("to_hold", 32'(instr_valid), 32'd1);
        instr_ack = 1;
        tick();
        instr_ack = 0;

        // flush colliding with mem_ready
        pc_in = 16'h0400; fetch_start = 1;
        tick();
        fetch_start = 0; flush = 1; mem_ready = 1; mem_rdata = 16'hBEEF;
        tick();
        flush = 0; mem_ready = 0;
        chk("fl_valid", 32'(instr_valid), 32'd0);
        chk("fl_req",   32'(mem_req), 32'd0);
        chk("fl_cnt",   32'(fetch_count), 32'd3);
        chk("fl_out",   32'(instr_out), 32'h1800);
        tick();
        chk("fl_idle", 32'(mem_req), 32'd0);

        // flush in HOLD with ack and start
        pc_in = 16'h0500; fetch_start = 1;
        tick();
        fetch_start = 0; mem_ready = 1; mem_rdata = 16'h1111;
        tick();
        mem_ready = 0;
        chk("fh_valid", 32'(instr_valid), 32'd1);
        chk("fh_cnt",   32'(fetch_count), 32'd4);
        flush = 1; instr_ack = 1; fetch_start = 1; pc_in = 16'h0600;
        tick();
        flush = 0; instr_ack = 0; fetch_start = 0;
        chk("fh_valid0", 32'(instr_valid), 32'd0);
        chk("fh_req",    32'(mem_req), 32'd0);
        chk("fh_out",    32'(instr_out), 32'h1111);
        tick();
        chk("fh_idle", 32'(mem_req), 32'd0);

        // back-to-back across counter wrap
        force dut.fetch_count_q = 16'hFFFE;
        #1;
        release dut.fetch_count_q;
        tick();
        chk("wr_pre", 32'(fetch_count), 32'hFFFE);
        pc_in = 16'h0700; fetch_start = 1;
        tick();
        fetch_start = 0; mem_ready = 1; mem_rdata = 16'h2222;
        tick();
        mem_ready = 0;
        chk("wr_ffff", 32'(fetch_count), 32'hFFFF);
        instr_ack = 1; fetch_start = 1; pc_in = 16'h0702;
        tick();
        instr_ack = 0; fetch_start = 0;
        chk("b2b_valid", 32'(instr_valid), 32'd0);
        chk("b2b_req",   32'(mem_req), 32'd1);
        chk("b2b_addr",  32'(mem_addr), 32'h0702);
        mem_ready = 1; mem_rdata = 16'h3333;
        tick();
        mem_ready = 0;
        chk("b2b_valid1", 32'(instr_valid), 32'd1);
        chk("b2b_out",    32'(instr_out), 32'h3333);
        chk("b2b_pc",     32'(instr_pc), 32'h0702);
        chk("wr_zero",    32'(fetch_count), 32'd0);
        instr_ack = 1;
        tick();
        instr_ack = 0;

        // async reset in the middle of a request
        pc_in = 16'h0800; fetch_start = 1;
        tick();
        fetch_start = 0;
        chk("ar_req1", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_req",   32'(mem_req), 32'd0);
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_out",   32'(instr_out), 32'h1800);
        chk("ar_cnt",   32'(fetch_count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
